blc_offset_est: RTL and testbench

Black-level estimator. It is the producer of the per-channel offset consumed by the black-level compensation chain. It averages a programmable number of optical-black (dark) RGB samples and presents one packed offset word {R,G,B} on the stage handshake. Downstream compensation stages negate and apply the offset; this block outputs the raw, positive black level.

---
 rtl/blc_pkg.sv | 31 +++
 rtl/blc_chan_acc.sv | 67 ++++++
 rtl/blc_offset_est.sv | 151 +++++++++++++++
 tb/tb_blc_offset_est.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/blc_pkg.sv
// Shared definitions for the black-level compensation chain:
// estimator state encoding, stage transfer encodings and channel slice helpers.
package blc_pkg;

  // Estimator states; the fourth code is not reachable in normal operation
  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_ROUND = 2'd1,
    ST_HOLD  = 2'd2,
    ST_BAD   = 2'd3
  } blc_state_e;

  // Stage transfer encodings, {remove, insert}, shared with the compensation stages
  localparam logic [1:0] XFER_NONE   = 2'b00;
  localparam logic [1:0] XFER_INSERT = 2'b01;
  localparam logic [1:0] XFER_REMOVE = 2'b10;

  // MSB positions of the packed {R,G,B} word for a given channel width
  function automatic int r_msb(input int dw);
    return 3 * dw - 1;
  endfunction

  function automatic int g_msb(input int dw);
    return 2 * dw - 1;
  endfunction

  function automatic int b_msb(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/blc_chan_acc.sv
// One colour channel of the black-level estimator: a sum of dark samples that
// cannot overflow for 2^LOG2_SAMPLES full-scale inputs, and a registered
// round-half-up / saturating average of that sum.
module blc_chan_acc #(
  parameter int DATA_WIDTH   = 12,
  parameter int LOG2_SAMPLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  add_en,
  input  logic                  acc_clr,
  input  logic                  load_en,
  input  logic                  off_clr,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [DATA_WIDTH-1:0] offset
);

  localparam int AW = DATA_WIDTH + LOG2_SAMPLES;
  localparam logic [AW:0] HALF = (AW + 1)'(1) << (LOG2_SAMPLES - 1);
  localparam logic [DATA_WIDTH:0] MAX_V = {1'b0, {DATA_WIDTH{1'b1}}};

  logic [AW-1:0]         acc_r;
  logic [DATA_WIDTH-1:0] offset_r;
  logic [AW:0]           sum_s;
  logic [DATA_WIDTH:0]   rnd_s;
  logic [DATA_WIDTH-1:0] offset_s;

  // Running sum of accepted samples; clear wins over a coincident add
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_r <= '0;
    end else if (acc_clr) begin
      acc_r <= '0;
    end else if (add_en) begin
      acc_r <= acc_r + {{LOG2_SAMPLES{1'b0}}, sample};
    end else begin
      acc_r <= acc_r;
    end
  end

  // Round half up by adding half an LSB of the average, then clamp to full scale
  always_comb begin
    sum_s = {1'b0, acc_r} + HALF;
    rnd_s = sum_s[AW:LOG2_SAMPLES];
    if (rnd_s > MAX_V) begin
      offset_s = {DATA_WIDTH{1'b1}};
    end else begin
      offset_s = rnd_s[DATA_WIDTH-1:0];
    end
  end

  // Published estimate; only reloaded when a new average is ready
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      offset_r <= '0;
    end else if (off_clr) begin
      offset_r <= '0;
    end else if (load_en) begin
      offset_r <= offset_s;
    end else begin
      offset_r <= offset_r;
    end
  end

  assign offset = offset_r;

endmodule

// File: rtl/blc_offset_est.sv
// Black-level estimator: averages 2^LOG2_SAMPLES dark RGB samples and offers
// the raw (positive) per-channel black level on the stage handshake.
module blc_offset_est
  import blc_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int LOG2_SAMPLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    u_i_ready,
  output logic                    i_i_ready,
  input  logic [3*DATA_WIDTH-1:0] data_in,
  input  logic                    clear,
  input  logic                    u_r_ready,
  output logic                    i_r_ready,
  output logic [3*DATA_WIDTH-1:0] offset_out,
  output logic [LOG2_SAMPLES:0]   sample_cnt
);

  localparam int R_MSB = r_msb(DATA_WIDTH);
  localparam int G_MSB = g_msb(DATA_WIDTH);
  localparam int B_MSB = b_msb(DATA_WIDTH);
  localparam int CNT_W = LOG2_SAMPLES + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_SAMPLES) - 1);

  blc_state_e       state_r;
  blc_state_e       fsm_s;
  blc_state_e       state_s;
  logic             i_i_ready_r;
  logic             i_r_ready_r;
  logic [CNT_W-1:0] cnt_r;
  logic             insert_s;
  logic             remove_s;
  logic [1:0]       xfer_s;
  logic             bad_s;
  logic             add_en_s;
  logic             acc_clr_s;
  logic             load_en_s;

  assign insert_s = u_i_ready & i_i_ready_r;
  assign remove_s = i_r_ready_r & u_r_ready;
  assign xfer_s   = {remove_s, insert_s};

  // Next-state decode; clear overrides whatever the handshake would do
  always_comb begin
    fsm_s = ST_ACCUM;
    case (state_r)
      ST_ACCUM: begin
        if ((xfer_s == XFER_INSERT) && (cnt_r == CNT_LAST)) begin
          fsm_s = ST_ROUND;
        end else begin
          fsm_s = ST_ACCUM;
        end
      end
      ST_ROUND: fsm_s = ST_HOLD;
      ST_HOLD: begin
        if (xfer_s == XFER_REMOVE) begin
          fsm_s = ST_ACCUM;
        end else begin
          fsm_s = ST_HOLD;
        end
      end
      default: fsm_s = ST_ACCUM;
    endcase
    if (clear) begin
      state_s = ST_ACCUM;
    end else begin
      state_s = fsm_s;
    end
  end

  // Datapath controls: a cleared cycle discards its sample and its remove
  always_comb begin
    bad_s     = (state_r == ST_BAD);
    add_en_s  = insert_s & ~clear & (state_r == ST_ACCUM);
    acc_clr_s = clear | remove_s | bad_s;
    load_en_s = (state_r == ST_ROUND) & ~clear;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_s;
    end
  end

  // Handshake flags are registered from the next state so they are glitch-free
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_i_ready_r <= 1'b1;
      i_r_ready_r <= 1'b0;
    end else begin
      i_i_ready_r <= (state_s == ST_ACCUM);
      i_r_ready_r <= (state_s == ST_HOLD);
    end
  end

  // Samples accepted toward the current estimate; holds at N until removed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (acc_clr_s) begin
      cnt_r <= '0;
    end else if (add_en_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  blc_chan_acc #(.DATA_WIDTH(DATA_WIDTH), .LOG2_SAMPLES(LOG2_SAMPLES)) u_acc_r (
    .clock   (clock),
    .reset   (reset),
    .add_en  (add_en_s),
    .acc_clr (acc_clr_s),
    .load_en (load_en_s),
    .off_clr (bad_s),
    .sample  (data_in[R_MSB:G_MSB+1]),
    .offset  (offset_out[R_MSB:G_MSB+1])
  );

  blc_chan_acc #(.DATA_WIDTH(DATA_WIDTH), .LOG2_SAMPLES(LOG2_SAMPLES)) u_acc_g (
    .clock   (clock),
    .reset   (reset),
    .add_en  (add_en_s),
    .acc_clr (acc_clr_s),
    .load_en (load_en_s),
    .off_clr (bad_s),
    .sample  (data_in[G_MSB:B_MSB+1]),
    .offset  (offset_out[G_MSB:B_MSB+1])
  );

  blc_chan_acc #(.DATA_WIDTH(DATA_WIDTH), .LOG2_SAMPLES(LOG2_SAMPLES)) u_acc_b (
    .clock   (clock),
    .reset   (reset),
    .add_en  (add_en_s),
    .acc_clr (acc_clr_s),
    .load_en (load_en_s),
    .off_clr (bad_s),
    .sample  (data_in[B_MSB:0]),
    .offset  (offset_out[B_MSB:0])
  );

  assign i_i_ready  = i_i_ready_r;
  assign i_r_ready  = i_r_ready_r;
  assign sample_cnt = cnt_r;

endmodule

// File: tb/tb_blc_offset_est.sv
// Bench for blc_offset_est: directed and random dark-sample estimates checked
// against an arithmetic average model; a second instance covers LOG2_SAMPLES=1.
module tb_blc_offset_est;

  localparam int DW   = 12;
  localparam int L    = 4;
  localparam int N    = 16;
  localparam int MAXV = 4095;

  logic            clock     = 1'b0;
  logic            reset     = 1'b0;
  logic            u_i_ready = 1'b0;
  logic            clear     = 1'b0;
  logic            u_r_ready = 1'b0;
  logic [3*DW-1:0] data_in   = '0;
  logic            i_i_ready;
  logic            i_r_ready;
  logic [3*DW-1:0] offset_out;
  logic [L:0]      sample_cnt;

  logic            u_i_ready1 = 1'b0;
  logic            clear1     = 1'b0;
  logic            u_r_ready1 = 1'b0;
  logic [3*DW-1:0] data_in1   = '0;
  logic            i_i_ready1;
  logic            i_r_ready1;
  logic [3*DW-1:0] offset_out1;
  logic [1:0]      sample_cnt1;

  int total = 0;
  int bad   = 0;
  int sr = 0, sg = 0, sb = 0;
  logic [3*DW-1:0] exp_off = '0;
  logic [3*DW-1:0] prev_off;

  blc_offset_est #(.DATA_WIDTH(DW), .LOG2_SAMPLES(L)) dut (
    .clock(clock), .reset(reset), .u_i_ready(u_i_ready), .i_i_ready(i_i_ready),
    .data_in(data_in), .clear(clear), .u_r_ready(u_r_ready), .i_r_ready(i_r_ready),
    .offset_out(offset_out), .sample_cnt(sample_cnt)
  );

  blc_offset_est #(.DATA_WIDTH(DW), .LOG2_SAMPLES(1)) dut1 (
    .clock(clock), .reset(reset), .u_i_ready(u_i_ready1), .i_i_ready(i_i_ready1),
    .data_in(data_in1), .clear(clear1), .u_r_ready(u_r_ready1), .i_r_ready(i_r_ready1),
    .offset_out(offset_out1), .sample_cnt(sample_cnt1)
  );

  always #5 clock = ~clock;

  function automatic int avg(input int s, input int n);
    int a;
    a = (s + n / 2) / n;
    if (a > MAXV) a = MAXV;
    return a;
  endfunction

  function automatic logic [3*DW-1:0] pack(input int r, input int g, input int b);
    return {12'(r), 12'(g), 12'(b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One insert, driven at a falling edge and accepted at the next rising edge
  task automatic ins(input int r, input int g, input int b);
    chk("in_ready", i_i_ready, 1);
    u_i_ready = 1'b1;
    data_in   = pack(r, g, b);
    @(negedge clock);
    u_i_ready = 1'b0;
    sr += r; sg += g; sb += b;
  endtask

  // Called right after the Nth insert: result appears two edges after it
  task automatic finish_est();
    chk("lat1_r_ready", i_r_ready, 0);
    chk("lat1_i_ready", i_i_ready, 0);
    @(negedge clock);
    chk("lat2_r_ready", i_r_ready, 1);
    exp_off = pack(avg(sr, N), avg(sg, N), avg(sb, N));
    chk("offset", offset_out, exp_off);
    chk("cnt_full", sample_cnt, N);
  endtask

  task automatic remove_est();
    u_i_ready = 1'b0;
    u_r_ready = 1'b1;
    @(negedge clock);
    u_r_ready = 1'b0;
    chk("rm_r_ready", i_r_ready, 0);
    chk("rm_i_ready", i_i_ready, 1);
    chk("rm_cnt", sample_cnt, 0);
    sr = 0; sg = 0; sb = 0;
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clock);
    chk("rst_i_ready", i_i_ready, 1);
    chk("rst_r_ready", i_r_ready, 0);
    chk("rst_offset", offset_out, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst1_i_ready", i_i_ready1, 1);
    chk("rst1_offset", offset_out1, 0);
    reset = 1'b1;
    @(negedge clock);

    // flat 64 field
    for (int i = 0; i < N; i++) ins(64, 64, 64);
    finish_est();
    chk("t1_offset", offset_out, 36'h040040040);
    remove_est();

    // round half up and full-scale blue
    for (int i = 0; i < 8; i++) ins(10, 0, 4095);
    for (int i = 0; i < 8; i++) ins(11, 0, 4095);
    finish_est();
    chk("t2_offset", offset_out, {12'd11, 12'd0, 12'd4095});
    remove_est();

    // backpressure: upstream keeps offering, nothing is accepted, offset holds
    for (int i = 0; i < N; i++) ins($urandom_range(0, 4095), $urandom_range(0, 300), $urandom_range(0, 4095));
    finish_est();
    u_i_ready = 1'b1;
    data_in   = pack(1, 2, 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("bp_i_ready", i_i_ready, 0);
      chk("bp_r_ready", i_r_ready, 1);
      chk("bp_offset", offset_out, exp_off);
      chk("bp_cnt", sample_cnt, N);
    end
    remove_est();

    // random estimates with idle gaps and random backpressure
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        ins($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
      end
      finish_est();
      repeat ($urandom_range(0, 4)) @(negedge clock);
      chk("rand_hold", offset_out, exp_off);
      remove_est();
    end

    // clear together with the 6th insert: sample discarded, offset retained
    prev_off = exp_off;
    for (int i = 0; i < 5; i++) ins(7, 7, 7);
    chk("pre_clr_cnt", sample_cnt, 5);
    u_i_ready = 1'b1;
    clear     = 1'b1;
    data_in   = pack(999, 999, 999);
    @(negedge clock);
    clear     = 1'b0;
    u_i_ready = 1'b0;
    sr = 0; sg = 0; sb = 0;
    chk("clr_cnt", sample_cnt, 0);
    chk("clr_i_ready", i_i_ready, 1);
    chk("clr_r_ready", i_r_ready, 0);
    chk("clr_offset_kept", offset_out, prev_off);
    for (int i = 0; i < N; i++) ins(100, 100, 100);
    finish_est();
    chk("t4_offset", offset_out, {12'd100, 12'd100, 12'd100});

    // clear while holding beats a coincident remove
    clear     = 1'b1;
    u_r_ready = 1'b1;
    @(negedge clock);
    clear     = 1'b0;
    u_r_ready = 1'b0;
    sr = 0; sg = 0; sb = 0;
    chk("hclr_r_ready", i_r_ready, 0);
    chk("hclr_i_ready", i_i_ready, 1);
    chk("hclr_cnt", sample_cnt, 0);
    chk("hclr_offset_kept", offset_out, exp_off);

    // asynchronous reset while holding, between clock edges
    for (int i = 0; i < N; i++) ins($urandom_range(1, 4095), $urandom_range(1, 4095), $urandom_range(1, 4095));
    finish_est();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_offset", offset_out, 0);
    chk("arst_i_ready", i_i_ready, 1);
    chk("arst_r_ready", i_r_ready, 0);
    chk("arst_cnt", sample_cnt, 0);
    @(negedge clock);
    reset = 1'b1;
    sr = 0; sg = 0; sb = 0;
    @(negedge clock);

    // two-sample build: 4094.5 rounds up to the ceiling
    chk("n2_i_ready", i_i_ready1, 1);
    u_i_ready1 = 1'b1;
    data_in1   = pack(4095, 0, 4094);
    @(negedge clock);
    data_in1   = pack(4094, 1, 4094);
    @(negedge clock);
    u_i_ready1 = 1'b0;
    chk("n2_lat1", i_r_ready1, 0);
    @(negedge clock);
    chk("n2_lat2", i_r_ready1, 1);
    chk("n2_offset", offset_out1, pack(avg(8189, 2), avg(1, 2), avg(8188, 2)));
    chk("n2_offset_r", offset_out1[35:24], 4095);
    chk("n2_cnt", sample_cnt1, 2);
    u_r_ready1 = 1'b1;
    @(negedge clock);
    u_r_ready1 = 1'b0;
    chk("n2_rm_r_ready", i_r_ready1, 0);
    chk("n2_rm_i_ready", i_i_ready1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
